// File: rtl/mac_operand_feeder.sv
// Operand feeder for the multiply-accumulate unit: buffers multiplicand/multiplier
// pairs in a small FIFO, presents the head pair to the MAC and tracks vector boundaries.
module mac_operand_feeder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     feed_clk_i,
  input  logic                     feed_nreset_i,
  input  logic [4:0]               in_multiplicand_i,
  input  logic [4:0]               in_multiplier_i,
  input  logic                     in_last_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     fetch_i,
  output logic [4:0]               feed_multiplicand_o,
  output logic [4:0]               feed_multiplier_o,
  output logic                     vec_done_o,
  output logic [CNT_W-1:0]         vec_len_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  state_t state;
  state_t state_next;

  logic [10:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CNT_W-1:0] term_cnt;
  logic [10:0]      head;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             head_last;

  assign head      = mem[rd_ptr];
  assign head_last = head[0];
  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign push      = in_valid_i & in_ready_o;
  // A fetch on an empty FIFO is a no-op: the MAC sees the forced zero operands.
  assign pop       = fetch_i & ~empty;

  always_comb begin
    in_ready_o          = ~full && (state != FLUSH);
    feed_multiplicand_o = '0;
    feed_multiplier_o   = '0;
    if (!empty) begin
      feed_multiplicand_o = head[10:6];
      feed_multiplier_o   = head[5:1];
    end
  end

  assign fifo_count_o = count;

  always_ff @(posedge feed_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {in_multiplicand_i, in_multiplier_i, in_last_i};
    end
  end

  always_ff @(posedge feed_clk_i or negedge feed_nreset_i) begin
    if (!feed_nreset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge feed_clk_i or negedge feed_nreset_i) begin
    if (!feed_nreset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (push) state_next = in_last_i ? FLUSH : STREAM;
      end
      STREAM: begin
        if (push && in_last_i) state_next = FLUSH;
      end
      FLUSH: begin
        if (pop && head_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only one last-tagged entry can be buffered because FLUSH blocks pushes.
  always_ff @(posedge feed_clk_i or negedge feed_nreset_i) begin
    if (!feed_nreset_i) begin
      term_cnt   <= '0;
      vec_len_o  <= '0;
      vec_done_o <= 1'b0;
    end else begin
      vec_done_o <= pop & head_last;
      if (pop) begin
        if (head_last) begin
          vec_len_o <= term_cnt + 1'b1;
          term_cnt  <= '0;
        end else begin
          term_cnt  <= term_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Randomized bench for mac_operand_feeder: a queue-level reference model plus a
// per-vector scoreboard of expected lengths and dot products.
module tb_mac_operand_feeder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       in_a = '0;
  logic [4:0]       in_b = '0;
  logic             in_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             fetch = 1'b0;
  logic [4:0]       feed_a;
  logic [4:0]       feed_b;
  logic             vec_done;
  logic [CNT_W-1:0] vec_len;
  logic [CW-1:0]    fifo_count;

  always #5 clk = ~clk;

  mac_operand_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .feed_clk_i          (clk),
    .feed_nreset_i       (rst_n),
    .in_multiplicand_i   (in_a),
    .in_multiplier_i     (in_b),
    .in_last_i           (in_last),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .fetch_i             (fetch),
    .feed_multiplicand_o (feed_a),
    .feed_multiplier_o   (feed_b),
    .vec_done_o          (vec_done),
    .vec_len_o           (vec_len),
    .fifo_count_o        (fifo_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of {a,b,last}; a vector in flight
  // after its last pair blocks new pairs until that last pair is consumed.
  logic [10:0] m_q[$];
  bit          m_flush;
  bit          m_done;
  bit          m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_flush = 1'b0;
      m_done  = 1'b0;
      m_acc   = 1'b0;
    end else begin
      bit          do_push;
      bit          do_pop;
      logic [10:0] e;
      do_push = in_valid && (m_q.size() < DEPTH) && !m_flush;
      do_pop  = fetch && (m_q.size() > 0);
      m_done  = 1'b0;
      m_acc   = do_push;
      if (do_pop) begin
        e = m_q.pop_front();
        if (e[0]) begin
          m_done  = 1'b1;
          m_flush = 1'b0;
        end
      end
      if (do_push) begin
        m_q.push_back({in_a, in_b, in_last});
        if (in_last) m_flush = 1'b1;
      end
    end
  end

  // Scoreboard: expected per-vector length and dot product, queued at issue time.
  int exp_len[$];
  int exp_sum[$];
  int acc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc = 0;
    end else begin
      int ea;
      int eb;
      int l;
      int s;
      ea = 0;
      eb = 0;
      if (m_q.size() > 0) begin
        ea = int'(m_q[0][10:6]);
        eb = int'(m_q[0][5:1]);
      end
      check("fifo_count", int'(fifo_count), m_q.size());
      check("in_ready", int'(in_ready), int'((m_q.size() < DEPTH) && !m_flush));
      check("feed_multiplicand", int'(feed_a), ea);
      check("feed_multiplier", int'(feed_b), eb);
      check("vec_done", int'(vec_done), int'(m_done));
      if (vec_done) begin
        if (exp_len.size() == 0) begin
          check("vec_done_unexpected", 1, 0);
        end else begin
          l = exp_len.pop_front();
          s = exp_sum.pop_front();
          check("vec_len", int'(vec_len), l);
          check("dot_product", acc, s);
        end
        acc = 0;
      end
      if (fetch) acc += int'(feed_a) * int'(feed_b);
    end
  end

  // Fetch driver: 0 = manual, 1 = random percentage, 2 = every 4th cycle.
  int fetch_mode   = 0;
  int fetch_pct    = 0;
  bit manual_fetch = 1'b0;
  int fetch_phase  = 0;

  always @(posedge clk) begin
    #3;
    case (fetch_mode)
      1:       fetch = ($urandom_range(0, 99) < fetch_pct);
      2: begin
        fetch       = (fetch_phase == 3);
        fetch_phase = (fetch_phase + 1) % 4;
      end
      default: fetch = manual_fetch;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_pair(input logic [4:0] a, input logic [4:0] b, input logic last);
    int n;
    n        = 0;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!m_acc && n < 400);
    check("accept_timeout", int'(m_acc), 1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int av[$], input int bv[$], input int max_gap);
    int s;
    s = 0;
    foreach (av[i]) s += av[i] * bv[i];
    exp_len.push_back(av.size() % (1 << CNT_W));
    exp_sum.push_back(s);
    foreach (av[i]) begin
      send_pair(5'(av[i]), 5'(bv[i]), i == av.size() - 1);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic rand_vec(input int len, input int max_gap);
    int av[$];
    int bv[$];
    for (int i = 0; i < len; i++) begin
      av.push_back($urandom_range(0, 31));
      bv.push_back($urandom_range(0, 31));
    end
    send_vec(av, bv, max_gap);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_len.size() > 0 || m_q.size() > 0) && n < 3000) begin
      idle(1);
      n++;
    end
    check("drain_timeout", exp_len.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, int'(fifo_count), 0);
    check({tag, "_ready"}, int'(in_ready), 1);
    check({tag, "_mcand"}, int'(feed_a), 0);
    check({tag, "_mplier"}, int'(feed_b), 0);
    check({tag, "_done"}, int'(vec_done), 0);
    check({tag, "_len"}, int'(vec_len), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int qa[$];
    int qb[$];

    #12;
    check_reset_values("reset");
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Three-term vector fetched every 4th cycle: 3*4 + 5*6 + 7*2 = 56.
    fetch_mode = 2;
    qa = {3, 5, 7};
    qb = {4, 6, 2};
    send_vec(qa, qb, 0);
    wait_drain();

    // Fill to DEPTH with no fetching, then one fetch lets the fifth pair in.
    fetch_mode   = 0;
    manual_fetch = 1'b0;
    idle(2);
    qa = {1, 2, 3, 4, 5};
    qb = {7, 8, 9, 10, 11};
    exp_len.push_back(5);
    exp_sum.push_back(1*7 + 2*8 + 3*9 + 4*10 + 5*11);
    for (int i = 0; i < 4; i++) send_pair(5'(qa[i]), 5'(qb[i]), 1'b0);
    @(negedge clk);
    check("full_count", int'(fifo_count), DEPTH);
    check("full_ready", int'(in_ready), 0);
    @(posedge clk);
    #2;
    fork
      send_pair(5'(qa[4]), 5'(qb[4]), 1'b1);
      begin
        idle(3);
        manual_fetch = 1'b1;
        idle(1);
        manual_fetch = 1'b0;
      end
    join
    fetch_mode = 1;
    fetch_pct  = 100;
    wait_drain();

    // Single-pair vector stays in FLUSH until consumed.
    fetch_mode = 0;
    qa = {31};
    qb = {31};
    send_vec(qa, qb, 0);
    idle(3);
    @(negedge clk);
    check("flush_ready", int'(in_ready), 0);
    @(posedge clk);
    #2;
    fetch_mode = 1;
    fetch_pct  = 100;
    wait_drain();

    // Fetching on an empty FIFO, then push and fetch on the same edge.
    idle(5);
    qa = {9};
    qb = {10};
    send_vec(qa, qb, 0);
    wait_drain();

    // Back-to-back vectors of lengths 2 and 3.
    fetch_pct = 50;
    rand_vec(2, 0);
    rand_vec(3, 0);
    wait_drain();

    repeat (25) begin
      fetch_pct = $urandom_range(10, 100);
      rand_vec($urandom_range(1, 9), $urandom_range(0, 2));
    end
    fetch_pct = 100;
    wait_drain();

    // Term counter wraps modulo 2^CNT_W.
    rand_vec(257, 0);
    wait_drain();

    // Reset while a vector sits in FLUSH.
    fetch_mode = 0;
    rand_vec(3, 0);
    idle(2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_len.delete();
    exp_sum.delete();
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #2;
    fetch_mode = 1;
    fetch_pct  = 100;
    rand_vec(4, 1);
    wait_drain();

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
